// File: rtl/cordic_phase_gen.sv
// Phase sweep generator feeding the CORDIC rad input: 16.16 angles wrapped into [-pi, pi).
// Optional LFSR output dither is enabled by defining CORDIC_PHASE_DITHER_EN.
module cordic_phase_gen #(
    parameter int signed   PI_Q16     = 205887,
    parameter int signed   TWO_PI_Q16 = 411775,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stop,
    input  logic signed [31:0]      start_phase,
    input  logic signed [31:0]      step,
    input  logic        [CNT_W-1:0] count,
    output logic signed [31:0]      rad_out,
    output logic                    rad_valid,
    input  logic                    rad_ready,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             r_state;
    state_e             w_state_next;
    logic signed [31:0] r_phase;
    logic signed [31:0] r_step;
    logic [CNT_W-1:0]   r_remaining;
    logic               r_cont;
    logic               r_busy;

    logic               w_start;
    logic               w_xfer;
    logic               w_last;
    logic signed [31:0] w_phase_clamp;
    logic signed [31:0] w_step_clamp;
    logic signed [32:0] w_pi;
    logic signed [32:0] w_two_pi;
    logic signed [32:0] w_sum;
    logic signed [32:0] w_adj;

    assign w_start = (r_state == StIdle) && start;
    assign w_xfer  = (r_state == StRun) && rad_ready;
    assign w_last  = w_xfer && !r_cont && (r_remaining == CNT_W'(1));

    assign w_pi     = 33'(PI_Q16);
    assign w_two_pi = 33'(TWO_PI_Q16);

    always_comb begin
        w_phase_clamp = start_phase;
        if (start_phase > PI_Q16 - 1) begin
            w_phase_clamp = PI_Q16 - 1;
        end else if (start_phase < -PI_Q16) begin
            w_phase_clamp = -PI_Q16;
        end
        w_step_clamp = step;
        if (step > PI_Q16) begin
            w_step_clamp = PI_Q16;
        end else if (step < -PI_Q16) begin
            w_step_clamp = -PI_Q16;
        end
    end

    // Sum at 33 bits so the wrap decision sees the true value before truncation.
    always_comb begin
        w_sum = {r_phase[31], r_phase} + {r_step[31], r_step};
        w_adj = '0;
        if (w_sum >= w_pi) begin
            w_adj = -w_two_pi;
        end else if (w_sum < -w_pi) begin
            w_adj = w_two_pi;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != StIdle);
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (start) w_state_next = StRun;
            StRun: begin
                if (stop) begin
                    w_state_next = StIdle;
                end else if (w_last) begin
                    w_state_next = StDone;
                end
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_phase     <= '0;
            r_step      <= '0;
            r_remaining <= '0;
            r_cont      <= 1'b0;
        end else if (w_start) begin
            r_phase     <= w_phase_clamp;
            r_step      <= w_step_clamp;
            r_remaining <= count;
            r_cont      <= (count == '0);
        end else if (w_xfer) begin
            r_phase <= 32'(w_sum + w_adj);
            if (!r_cont) begin
                r_remaining <= r_remaining - CNT_W'(1);
            end
        end
    end

`ifdef CORDIC_PHASE_DITHER_EN
    logic [15:0] r_lfsr;
    logic        w_lfsr_fb;

    assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lfsr <= 16'hACE1;
        end else if (w_start) begin
            r_lfsr <= 16'hACE1;
        end else if (w_xfer) begin
            r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
        end
    end

    // Offset of -8..+7 LSB is deliberately not re-wrapped.
    always_comb begin
        rad_out = r_phase + ({28'b0, r_lfsr[3:0]} - 32'd8);
    end
`else
    always_comb begin
        rad_out = r_phase;
    end
`endif

    always_comb begin
        rad_valid = (r_state == StRun);
        done      = (r_state == StDone);
        busy      = r_busy;
    end

endmodule

// File: tb/tb_cordic_phase_gen.sv
// Self-checking bench for cordic_phase_gen: behavioural model, directed wrap/clamp/stop/reset
// cases and a randomized sweep loop with random backpressure and aborts.
module tb_cordic_phase_gen;

    localparam longint PI  = 205887;
    localparam longint TWO = 411775;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               stop;
    logic signed [31:0] start_phase;
    logic signed [31:0] step;
    logic        [15:0] count;
    logic signed [31:0] rad_out;
    logic               rad_valid;
    logic               rad_ready;
    logic               busy;
    logic               done;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    longint q[$];

    // Model state: 0 idle, 1 run, 2 done
    int          m_st = 0;
    longint      m_phase = 0;
    longint      m_step = 0;
    int          m_rem = 0;
    bit          m_cont = 0;
    logic [15:0] m_lfsr = 16'hACE1;

    cordic_phase_gen dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .start_phase (start_phase),
        .step        (step),
        .count       (count),
        .rad_out     (rad_out),
        .rad_valid   (rad_valid),
        .rad_ready   (rad_ready),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    function automatic longint clampv(input longint v, input longint lo, input longint hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic longint wrapv(input longint v);
        if (v >= PI) return v - TWO;
        if (v < -PI) return v + TWO;
        return v;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        logic fb;
        fb = l[0] ^ l[2] ^ l[3] ^ l[5];
        return {fb, l[15:1]};
    endfunction

    function automatic longint m_out();
`ifdef CORDIC_PHASE_DITHER_EN
        return m_phase + longint'(m_lfsr[3:0]) - 8;
`else
        return m_phase;
`endif
    endfunction

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_st <= 0; m_phase <= 0; m_step <= 0; m_rem <= 0; m_cont <= 0;
            m_lfsr <= 16'hACE1;
        end else begin
            case (m_st)
                0: if (start) begin
                    m_st    <= 1;
                    m_phase <= clampv(longint'(start_phase), -PI, PI - 1);
                    m_step  <= clampv(longint'(step), -PI, PI);
                    m_rem   <= int'(count);
                    m_cont  <= (count == 0);
                    m_lfsr  <= 16'hACE1;
                end
                1: begin
                    if (rad_ready) begin
                        m_phase <= wrapv(m_phase + m_step);
                        m_rem   <= m_rem - 1;
                        m_lfsr  <= lfsr_next(m_lfsr);
                    end
                    if (stop) m_st <= 0;
                    else if (rad_ready && !m_cont && m_rem == 1) m_st <= 2;
                end
                default: m_st <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        check("valid", rad_valid, m_st == 1);
        check("busy", busy, m_st != 0);
        check("done", done, m_st == 2);
        if (m_st == 1) check("rad_out", rad_out, m_out());
    end

    always @(negedge clk) begin
        if (rad_valid && rad_ready) q.push_back(rad_out);
        if (done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int sp, input int st, input int cnt);
        start_phase = sp;
        step        = st;
        count       = 16'(cnt);
        start       = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        if (busy) check("idle_timeout", busy, 0);
    endtask

    task automatic clear_log();
        q.delete();
        done_cnt = 0;
    endtask

    initial begin
        longint exp_p[5];
        longint exp_n[2];
        longint h;
        start = 0; stop = 0; start_phase = 0; step = 0; count = 0; rad_ready = 1; rst = 1;
        #1 rst = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rad_out", rad_out, 0);
        check("rst_valid", rad_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1;
        tick();

        // Positive wrap
        clear_log();
        exp_p = '{0, 65536, 131072, 196608, -149631};
        do_start(0, 65536, 5);
        wait_idle(50);
        check("pos_len", q.size(), 5);
        check("pos_done", done_cnt, 1);
`ifndef CORDIC_PHASE_DITHER_EN
        for (int i = 0; i < 5 && i < q.size(); i++) check("pos_seq", q[i], exp_p[i]);
`endif

        // Negative wrap
        clear_log();
        exp_n = '{-196608, 149631};
        do_start(-196608, -65536, 2);
        wait_idle(50);
        check("neg_len", q.size(), 2);
        check("neg_done", done_cnt, 1);
`ifndef CORDIC_PHASE_DITHER_EN
        for (int i = 0; i < 2 && i < q.size(); i++) check("neg_seq", q[i], exp_n[i]);
`endif

        // Backpressure
        clear_log();
        do_start(0, 1000, 8);
        tick();
        tick();
        rad_ready = 0;
        h = rad_out;
        repeat (3) begin
            tick();
            check("bp_hold", rad_out, h);
            check("bp_valid", rad_valid, 1);
        end
        rad_ready = 1;
        tick();
`ifndef CORDIC_PHASE_DITHER_EN
        check("bp_next", rad_out, h + 1000);
`endif
        wait_idle(50);
        check("bp_len", q.size(), 8);
        check("bp_done", done_cnt, 1);
`ifndef CORDIC_PHASE_DITHER_EN
        for (int i = 0; i < 8 && i < q.size(); i++) check("bp_seq", q[i], i * 1000);
`endif

        // Clamp and continuous
        clear_log();
        do_start(500000, 300000, 0);
`ifndef CORDIC_PHASE_DITHER_EN
        check("clamp_first", rad_out, 205886);
        tick();
        check("clamp_second", rad_out, -2);
`else
        tick();
`endif
        repeat (1000) tick();
        check("cont_nodone", done_cnt, 0);
        check("cont_busy", busy, 1);
        stop = 1;
        tick();
        stop = 0;
        check("cont_stop_valid", rad_valid, 0);

        // Stop on third transfer
        tick();
        clear_log();
        do_start(1000, 5000, 10);
        tick();
        tick();
        stop = 1;
        tick();
        stop = 0;
        check("stop_valid", rad_valid, 0);
        check("stop_busy", busy, 0);
        check("stop_len", q.size(), 3);
        repeat (3) tick();
        check("stop_nodone", done_cnt, 0);

        // Asynchronous reset mid-run
        do_start(1234, 777, 10);
        tick();
        tick();
        #2 rst = 0;
        #1;
        check("arst_rad_out", rad_out, 0);
        check("arst_valid", rad_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        @(negedge clk);
        #1 rst = 1;
        tick();

`ifdef CORDIC_PHASE_DITHER_EN
        do_start(0, 0, 4);
        check("dither_first", rad_out, -7);
        tick();
        check("dither_second", rad_out, -8);
        wait_idle(50);
`endif

        // Randomized sweeps
        for (int r = 0; r < 40; r++) begin
            int cnt;
            int n;
            cnt = ($urandom_range(4) == 0) ? 0 : int'($urandom_range(12, 1));
            stop = ($urandom_range(3) == 0);
            do_start(int'($urandom_range(800000)) - 400000,
                     int'($urandom_range(600000)) - 300000, cnt);
            n = 0;
            while (busy && n < 200) begin
                rad_ready = ($urandom_range(3) != 0);
                stop = (cnt == 0 && n > 15) || ($urandom_range(24) == 0);
                start = ($urandom_range(9) == 0);
                tick();
                n++;
            end
            start = 0;
            stop = 1;
            tick();
            stop = 0;
            rad_ready = 1;
            tick();
            check("rand_idle", busy, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
